// File: rtl/data_bus_ctrl_if.sv
// Data-side CPU bus: word address, write data, write strobe and combinational read data.
// The CPU drives the master side; data_bus_ctrl implements the slave side.
interface data_bus_ctrl_if;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic        mem_wr_en;
  logic [15:0] data_rdata;

  modport master (
    output data_addr,
    output data_wdata,
    output mem_wr_en,
    input  data_rdata
  );

  modport slave (
    input  data_addr,
    input  data_wdata,
    input  mem_wr_en,
    output data_rdata
  );
endinterface

// File: rtl/data_bus_ctrl.sv
// Data bus decoder: word RAM, GPIO port and a prescaled compare timer.
// Define DBUS_WR_ERR_EN to trap writes to read-only/unmapped addresses.
module data_bus_ctrl #(
  parameter int          RAM_AW  = 8,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic         clk,
  input  logic         rst_n,
  data_bus_ctrl_if.slave bus,
  output logic [15:0]  gpio_out,
  input  logic [15:0]  gpio_in,
  output logic         timer_irq
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [15:0] ram [RAM_DEPTH];

  logic        wr;
  logic        ram_hit;
  logic        io_hit;
  logic [16:0] io_delta;
  logic [2:0]  io_off;
  logic        sel_gpo;
  logic        sel_gpi;
  logic        sel_cnt;
  logic        sel_cmp;
  logic        sel_ctrl;
  logic        sel_stat;
  logic        sel_eaddr;

  logic [15:0] gpio_s1;
  logic [15:0] gpio_s2;

  logic [15:0] cnt;
  logic [15:0] cmp;
  logic        en;
  logic        com;
  logic        ie;
  logic [3:0]  p;
  logic [3:0]  pcnt;
  logic        flag;

  logic        tick;
  logic        match;
  logic        w1c0;
  logic        p_chg;
  logic        err_bit;
  logic [15:0] eaddr_rd;

  assign wr       = bus.mem_wr_en;
  assign ram_hit  = 32'(bus.data_addr) < 32'(RAM_DEPTH);
  // Borrow or any bit above [2] means the address is outside the 8-word block
  assign io_delta = {1'b0, bus.data_addr} - {1'b0, IO_BASE};
  assign io_hit   = io_delta[16:3] == '0;
  assign io_off   = io_delta[2:0];

  assign sel_gpo   = io_hit && io_off == 3'd0;
  assign sel_gpi   = io_hit && io_off == 3'd1;
  assign sel_cnt   = io_hit && io_off == 3'd2;
  assign sel_cmp   = io_hit && io_off == 3'd3;
  assign sel_ctrl  = io_hit && io_off == 3'd4;
  assign sel_stat  = io_hit && io_off == 3'd5;
  assign sel_eaddr = io_hit && io_off == 3'd6;

  assign tick  = en && pcnt == p;
  assign match = tick && cnt == cmp;
  assign w1c0  = wr && sel_stat && bus.data_wdata[0];
  assign p_chg = wr && sel_ctrl && bus.data_wdata[7:4] != p;

  always_ff @(posedge clk) begin
    if (wr && ram_hit) begin
      ram[bus.data_addr[RAM_AW-1:0]] <= bus.data_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= '0;
    end else if (wr && sel_gpo) begin
      gpio_out <= bus.data_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_s1 <= '0;
      gpio_s2 <= '0;
    end else begin
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= 1'b0;
      com <= 1'b0;
      ie  <= 1'b0;
      p   <= '0;
      cmp <= '0;
    end else begin
      if (wr && sel_ctrl) begin
        en  <= bus.data_wdata[0];
        com <= bus.data_wdata[1];
        ie  <= bus.data_wdata[2];
        p   <= bus.data_wdata[7:4];
      end
      if (wr && sel_cmp) begin
        cmp <= bus.data_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (p_chg || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 4'd1;
    end
  end

  // A CPU write to the count takes priority over the tick update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wr && sel_cnt) begin
      cnt <= bus.data_wdata;
    end else if (tick) begin
      cnt <= (match && com) ? 16'd0 : cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else begin
      flag <= match || (flag && !w1c0);
    end
  end

  assign timer_irq = flag && ie;

`ifdef DBUS_WR_ERR_EN
  logic        err_flag;
  logic [15:0] err_addr;
  logic        wr_bad;
  logic        w1c1;
  logic        capture;

  assign wr_bad  = wr && !(ram_hit || sel_gpo || sel_cnt ||
                           sel_cmp || sel_ctrl || sel_stat);
  assign w1c1    = wr && sel_stat && bus.data_wdata[1];
  assign capture = wr_bad && (!err_flag || w1c1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else begin
      err_flag <= wr_bad || (err_flag && !w1c1);
      if (capture) begin
        err_addr <= bus.data_addr;
      end
    end
  end

  assign err_bit  = err_flag;
  assign eaddr_rd = err_addr;
`else
  assign err_bit  = 1'b0;
  assign eaddr_rd = '0;
`endif

  always_comb begin
    bus.data_rdata = '0;
    unique case (1'b1)
      ram_hit:   bus.data_rdata = ram[bus.data_addr[RAM_AW-1:0]];
      sel_gpo:   bus.data_rdata = gpio_out;
      sel_gpi:   bus.data_rdata = gpio_s2;
      sel_cnt:   bus.data_rdata = cnt;
      sel_cmp:   bus.data_rdata = cmp;
      sel_ctrl:  bus.data_rdata = {8'd0, p, 1'b0, ie, com, en};
      sel_stat:  bus.data_rdata = {14'd0, err_bit, flag};
      sel_eaddr: bus.data_rdata = eaddr_rd;
      default:   bus.data_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Testbench for data_bus_ctrl: vector table, timer/reset sequences, random vs model.
// Honours DBUS_WR_ERR_EN for the write-error checks.
module tb_data_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in;
  logic        timer_irq;

  data_bus_ctrl_if bus();

  data_bus_ctrl #(
    .RAM_AW (8),
    .IO_BASE(16'hFF00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

`ifdef DBUS_WR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at negedge; pre = read before the edge, post = read after it
  task automatic step(input logic [15:0] a, input logic [15:0] d,
                      input logic we, output logic [15:0] pre,
                      output logic [15:0] post);
    @(negedge clk);
    bus.data_addr  = a;
    bus.data_wdata = d;
    bus.mem_wr_en  = we;
    #1 pre = bus.data_rdata;
    @(posedge clk);
    #1 post = bus.data_rdata;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        we;
    logic        ck;
    logic [15:0] exp;
  } vec_t;

  vec_t tv[$];

  // Reference model state
  logic [15:0] m_ram [16];
  bit          m_val [16];
  logic [15:0] m_gpio, m_cnt, m_cmp, m_ctrl, m_eaddr;
  int          m_phase;
  bit          m_flag, m_err;
  logic [15:0] m_gq[$];

  function automatic logic [16:0] m_read(input logic [15:0] a);
    if (a < 16'h0100) begin
      if (a < 16'd16 && m_val[a[3:0]]) return {1'b1, m_ram[a[3:0]]};
      return 17'h0;
    end
    case (a)
      16'hFF00: return {1'b1, m_gpio};
      16'hFF01: return {1'b1, m_gq[0]};
      16'hFF02: return {1'b1, m_cnt};
      16'hFF03: return {1'b1, m_cmp};
      16'hFF04: return {1'b1, m_ctrl & 16'h00F7};
      16'hFF05: return {1'b1, 14'd0, m_err, m_flag};
      16'hFF06: return {1'b1, ERR_EN ? m_eaddr : 16'h0};
      default:  return {1'b1, 16'h0};
    endcase
  endfunction

  task automatic m_reset();
    m_gpio = 0; m_cnt = 0; m_cmp = 0; m_ctrl = 0; m_eaddr = 0;
    m_phase = 0; m_flag = 0; m_err = 0;
    for (int i = 0; i < 16; i++) m_val[i] = 0;
    m_gq.delete();
    m_gq.push_back(16'h0);
    m_gq.push_back(16'h0);
  endtask

  task automatic m_clock(input logic [15:0] a, input logic [15:0] d,
                         input bit we, input logic [15:0] gin);
    bit en, tick, match, bad, w1c0, w1c1;
    int p;
    en    = m_ctrl[0];
    p     = int'(m_ctrl[7:4]);
    tick  = en && m_phase == p;
    match = tick && m_cnt == m_cmp;
    w1c0  = we && a == 16'hFF05 && d[0];
    w1c1  = we && a == 16'hFF05 && d[1];
    bad   = we && !(a < 16'h0100 || a == 16'hFF00 || a == 16'hFF02 ||
                    a == 16'hFF03 || a == 16'hFF04 || a == 16'hFF05);
    if (we && a == 16'hFF04 && d[7:4] != m_ctrl[7:4]) m_phase = 0;
    else if (!en || tick) m_phase = 0;
    else m_phase = m_phase + 1;
    if (we && a == 16'hFF02) m_cnt = d;
    else if (tick) m_cnt = (match && m_ctrl[1]) ? 16'h0 : 16'(m_cnt + 16'd1);
    m_flag = match || (m_flag && !w1c0);
    if (ERR_EN && bad && (!m_err || w1c1)) m_eaddr = a;
    m_err = ERR_EN && (bad || (m_err && !w1c1));
    if (we && a < 16'd16) begin
      m_ram[a[3:0]] = d;
      m_val[a[3:0]] = 1;
    end
    if (we && a == 16'hFF00) m_gpio = d;
    if (we && a == 16'hFF03) m_cmp = d;
    if (we && a == 16'hFF04) m_ctrl = d;
    m_gq.push_back(gin);
    void'(m_gq.pop_front());
  endtask

  initial begin
    logic [15:0] pre, post;
    logic [15:0] ra, rd, ex;
    logic        rwe;
    logic [16:0] mr;
    int          sel;

    bus.data_addr  = 16'h0;
    bus.data_wdata = 16'h0;
    bus.mem_wr_en  = 1'b0;
    gpio_in        = 16'h0;

    tv.push_back('{16'h0003, 16'hA5A5, 1'b1, 1'b0, 16'h0000});
    tv.push_back('{16'h00FF, 16'h1234, 1'b1, 1'b0, 16'h0000});
    tv.push_back('{16'h0003, 16'h0000, 1'b0, 1'b1, 16'hA5A5});
    tv.push_back('{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h1234});
    tv.push_back('{16'h0100, 16'h0000, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{16'hFF00, 16'h00F0, 1'b1, 1'b1, 16'h0000});
    tv.push_back('{16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h00F0});
    tv.push_back('{16'hFF03, 16'h1234, 1'b1, 1'b1, 16'h0000});
    tv.push_back('{16'hFF03, 16'h0000, 1'b0, 1'b1, 16'h1234});
    tv.push_back('{16'hFF04, 16'hFF08, 1'b1, 1'b0, 16'h0000});
    tv.push_back('{16'hFF04, 16'h0000, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{16'hFF04, 16'h00F6, 1'b1, 1'b0, 16'h0000});
    tv.push_back('{16'hFF04, 16'h0000, 1'b0, 1'b1, 16'h00F6});
    tv.push_back('{16'hFF04, 16'h0000, 1'b1, 1'b0, 16'h0000});
    tv.push_back('{16'hFF07, 16'h0000, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{16'hFF06, 16'h0000, 1'b0, 1'b1, 16'h0000});
    tv.push_back('{16'hFF05, 16'h0000, 1'b0, 1'b1, 16'h0000});

    // Reset state, read combinationally while rst_n is low
    #2;
    chk("rst_gpio_out", gpio_out, 16'h0);
    chk("rst_irq", 16'(timer_irq), 16'h0);
    bus.data_addr = 16'hFF02; #1 chk("rst_cnt", bus.data_rdata, 16'h0);
    bus.data_addr = 16'hFF04; #1 chk("rst_ctrl", bus.data_rdata, 16'h0);
    bus.data_addr = 16'hFF05; #1 chk("rst_status", bus.data_rdata, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].a, tv[i].d, tv[i].we, pre, post);
      if (tv[i].ck) chk($sformatf("vec%0d", i), pre, tv[i].exp);
    end
    chk("gpio_out_port", gpio_out, 16'h00F0);

    // GPIO input synchronizer latency
    @(negedge clk);
    bus.data_addr = 16'hFF01;
    bus.mem_wr_en = 1'b0;
    gpio_in = 16'hBEEF;
    #1 chk("gpi_0cyc", bus.data_rdata, 16'h0000);
    @(posedge clk); #1 chk("gpi_1cyc", bus.data_rdata, 16'h0000);
    @(posedge clk); #1 chk("gpi_2cyc", bus.data_rdata, 16'hBEEF);

    // Timer match with clear-on-match and irq
    step(16'hFF03, 16'd5, 1'b1, pre, post);
    step(16'hFF04, 16'h0007, 1'b1, pre, post);
    for (int k = 1; k <= 6; k++) begin
      step(16'hFF02, 16'h0, 1'b0, pre, post);
      chk($sformatf("match_cnt%0d", k), post, (k < 6) ? 16'(k) : 16'h0);
      chk($sformatf("match_irq%0d", k), 16'(timer_irq), (k >= 6) ? 16'h1 : 16'h0);
    end
    step(16'hFF05, 16'h0001, 1'b1, pre, post);
    chk("w1c_irq", 16'(timer_irq), 16'h0);
    chk("w1c_status", post, 16'h0);
    for (int k = 8; k <= 11; k++) step(16'hFF02, 16'h0, 1'b0, pre, post);
    chk("pre_collide_cnt", post, 16'd5);
    step(16'hFF05, 16'h0001, 1'b1, pre, post);
    chk("collide_status", post, 16'h0001);
    chk("collide_irq", 16'(timer_irq), 16'h1);

    // Asynchronous reset while counting
    step(16'hFF02, 16'h0, 1'b0, pre, post);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_gpio_out", gpio_out, 16'h0);
    chk("arst_irq", 16'(timer_irq), 16'h0);
    chk("arst_cnt", bus.data_rdata, 16'h0);
    bus.data_addr = 16'hFF04; #1 chk("arst_ctrl", bus.data_rdata, 16'h0);
    bus.data_addr = 16'h0003; #1 chk("arst_ram_kept", bus.data_rdata, 16'hA5A5);
    @(negedge clk);
    rst_n = 1'b1;

    // Prescale, wrap and CPU write on a tick
    step(16'hFF02, 16'hFFFE, 1'b1, pre, post);
    step(16'hFF04, 16'h0031, 1'b1, pre, post);
    for (int k = 1; k <= 16; k++) begin
      if (k == 12) step(16'hFF02, 16'h0010, 1'b1, pre, post);
      else step(16'hFF02, 16'h0, 1'b0, pre, post);
      ex = (k < 4) ? 16'hFFFE : (k < 8) ? 16'hFFFF : (k < 12) ? 16'h0000 :
           (k < 16) ? 16'h0010 : 16'h0011;
      chk($sformatf("presc_cnt%0d", k), post, ex);
    end
    step(16'hFF04, 16'h0000, 1'b1, pre, post);
    step(16'hFF05, 16'h0003, 1'b1, pre, post);

`ifdef DBUS_WR_ERR_EN
    step(16'hFF01, 16'h1111, 1'b1, pre, post);
    step(16'hFF05, 16'h0, 1'b0, pre, post);
    chk("err_status", pre, 16'h0002);
    step(16'hFF06, 16'h0, 1'b0, pre, post);
    chk("err_addr", pre, 16'hFF01);
    step(16'h8000, 16'h2222, 1'b1, pre, post);
    step(16'hFF06, 16'h0, 1'b0, pre, post);
    chk("err_addr_first", pre, 16'hFF01);
    step(16'hFF05, 16'h0002, 1'b1, pre, post);
    step(16'hFF05, 16'h0, 1'b0, pre, post);
    chk("err_cleared", pre, 16'h0000);
`else
    step(16'hFF01, 16'h1111, 1'b1, pre, post);
    step(16'hFF05, 16'h0, 1'b0, pre, post);
    chk("noerr_status", pre, 16'h0000);
    step(16'hFF06, 16'h0, 1'b0, pre, post);
    chk("noerr_addr", pre, 16'h0000);
`endif

    // Randomized run against the model, from a clean reset
    @(negedge clk);
    bus.mem_wr_en = 1'b0;
    bus.data_addr = 16'h0;
    gpio_in = 16'h0;
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      sel = int'($urandom_range(0, 9));
      if (sel < 4) ra = 16'($urandom_range(0, 15));
      else if (sel < 9) ra = 16'hFF00 + 16'($urandom_range(0, 7));
      else ra = 16'($urandom_range(16'h0100, 16'hFEFF));
      rwe = $urandom_range(0, 1) == 1;
      rd = 16'($urandom);
      if (ra == 16'hFF02 || ra == 16'hFF03) rd = 16'($urandom_range(0, 12));
      if (ra == 16'hFF04) begin
        rd[7:4] = 4'($urandom_range(0, 2));
        rd[0] = $urandom_range(0, 3) != 0;
      end
      bus.data_addr  = ra;
      bus.data_wdata = rd;
      bus.mem_wr_en  = rwe;
      gpio_in = 16'($urandom);
      #1;
      mr = m_read(ra);
      if (mr[16]) chk($sformatf("rnd%0d_rdata@%h", c, ra), bus.data_rdata, mr[15:0]);
      chk($sformatf("rnd%0d_gpio_out", c), gpio_out, m_gpio);
      chk($sformatf("rnd%0d_irq", c), 16'(timer_irq), 16'(m_flag && m_ctrl[2]));
      @(posedge clk);
      m_clock(ra, rd, rwe, gpio_in);
    end

    @(negedge clk);
    bus.mem_wr_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_ctrl.md
Name: data_bus_ctrl

Overview:
- Downstream data-side stage of the CPU top level. Consumes its data address, write data and memory write enable; returns read data.
- Decodes each access into one of:
  - a word-addressed data RAM;
  - a GPIO output/input port pair;
  - a prescaled 16-bit timer with compare-match flag and interrupt.
- Reads are combinational, so the multicycle controller can sample read data in the same state it drives the address.

Parameters:
- RAM_AW, 8, RAM address width; RAM holds 2^RAM_AW 16-bit words at addresses 0 to 2^RAM_AW-1.
- IO_BASE, 16'hFF00, base address of the peripheral register block (8 words, IO_BASE+0 to IO_BASE+7).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- data_addr  in  16  word address from CPU
- data_wdata  in  16  write data from CPU
- mem_wr_en  in  1  write strobe; write occurs on the rising edge while high
- data_rdata  out  16  combinational read data for data_addr
- gpio_out  out  16  GPIO output register
- gpio_in  in  16  asynchronous external inputs
- timer_irq  out  1  level interrupt = match flag AND irq enable

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - gpio_out, TIMER_CNT, TIMER_CMP, TIMER_CTRL, prescale counter, match flag and both gpio sync stages clear to 0.
  - timer_irq is 0 after reset.
  - RAM contents are not reset.
- Address map (word addresses):
  - below 2^RAM_AW: RAM, read/write.
  - IO_BASE+0 GPIO_OUT: read/write.
  - IO_BASE+1 GPIO_IN: read-only; returns the 2-flop-synchronized gpio_in, 2-cycle latency.
  - IO_BASE+2 TIMER_CNT: read/write.
  - IO_BASE+3 TIMER_CMP: read/write.
  - IO_BASE+4 TIMER_CTRL, read/write:
    - bit0 enable;
    - bit1 clear-on-match;
    - bit2 irq enable;
    - bits[7:4] prescale P;
    - bits[15:8] read 0.
  - IO_BASE+5 STATUS: bit0 match flag; writing 1 to bit0 clears it (W1C); other bits read 0.
  - IO_BASE+6, IO_BASE+7 and every other address: read 0, writes ignored.
- Read path: data_rdata is purely combinational from data_addr and current register/RAM state. A same-cycle write is not forwarded; the new value is visible the cycle after the edge.
- Timer:
  - When enable=1, the prescale counter counts 0..P. A tick occurs on the cycle it equals P, then it returns to 0. P=0 gives a tick every cycle.
  - When enable=0, the prescale counter holds at 0 and the count does not advance.
  - On a tick, TIMER_CNT increments modulo 2^16 (0xFFFF wraps to 0x0000).
  - If TIMER_CNT==TIMER_CMP on a tick:
    - the match flag sets;
    - if clear-on-match=1, TIMER_CNT loads 0 instead of incrementing.
- Simultaneous events:
  - CPU write to TIMER_CNT on a tick cycle: the CPU value wins.
  - Match-flag set and W1C in the same cycle: the set wins, flag stays 1.
  - Write to TIMER_CTRL changing P: the prescale counter resets to 0 on that edge.
- Reset asserted mid-operation: all registers clear immediately. An in-flight write is lost.

Optional Feature:
- Macro: DBUS_WR_ERR_EN.
- Defined:
  - A write to a read-only or unmapped address (IO_BASE+1, IO_BASE+6, IO_BASE+7, or any address outside RAM and IO space) sets sticky STATUS bit1.
  - It also captures data_addr into ERR_ADDR, which reads at IO_BASE+6.
  - Only the first error is captured until bit1 is cleared via W1C.
  - If a W1C of bit1 and a new error occur in the same cycle, the error wins and ERR_ADDR is updated.
  - ERR_ADDR resets to 0.
- Not defined: such writes are silently ignored, STATUS bit1 reads 0, and IO_BASE+6 reads 0.

Test Plan:
- RAM round trip: write 0xA5A5 @0x0003 and 0x1234 @0x00FF, then read both -> 0xA5A5 and 0x1234; read @0x0100 -> 0x0000.
- GPIO: write 0x00F0 @0xFF00 -> gpio_out=0x00F0 the next cycle. Drive gpio_in=0xBEEF -> @0xFF01 reads 0xBEEF exactly 2 cycles later, not earlier.
- Timer match and interrupt:
  - CMP=5, CTRL=0x0007 (P=0, enable, clear-on-match, irq enable) -> flag and timer_irq rise after the 6th tick; CNT returns to 0.
  - W1C 0x0001 @0xFF05 -> timer_irq=0.
- Prescale and wrap:
  - CTRL=0x0031 (P=3, enable), CNT=0xFFFE -> CNT reads 0xFFFF after 4 cycles and 0x0000 after 8.
  - Writing CNT=0x0010 on a tick cycle -> reads 0x0010.
- Collisions and reset:
  - W1C on the same cycle the match occurs -> flag stays 1.
  - Assert rst_n low mid-count -> gpio_out, CNT, CTRL and timer_irq read 0 immediately, without waiting for a clock edge.
- With DBUS_WR_ERR_EN:
  - Write @0xFF01 -> STATUS=0x0002 and @0xFF06 reads 0xFF01.
  - A second bad write @0x8000 leaves ERR_ADDR=0xFF01.
  - Without the macro: STATUS=0x0000.
